dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
//  Parametrised store path between MEM stage and data memory: aligns sb/sh/sw data and byte enables,
//  queues stores in a DEPTH-entry FIFO, optionally merges same-word stores, and drains to the DM bus
//  via valid/ready. Flags misaligned stores and exposes a load-hazard check so MEM can stall loads.
// PARAMETERS
//  DATA_W  32  memory word width in bits; power of two, >=32; BYTES=DATA_W/8
//  ADDR_W  32  byte address width
//  DEPTH   4   FIFO entries; power of two, >=1
//  MERGE   1   1 = merge a store into the newest entry when word addresses match; 0 = never merge
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous reset, active low
//  st_valid     in   1               store request from MEM
//  st_ready     out  1               store accepted this cycle when st_valid&&st_ready
//  st_addr      in   ADDR_W          byte address
//  st_wdata     in   DATA_W          unaligned store data (low bits significant)
//  st_type      in   6               `Word_DM/`Half_DM/`Unsigned_Half_DM/`Byte_DM/`Unsigned_Byte_DM
//  st_misalign  out  1               one-cycle pulse, cycle after accepting a misaligned store
//  ld_addr      in   ADDR_W          load byte address for hazard check
//  ld_conflict  out  1               comb: some valid entry holds word address of ld_addr
//  mem_valid    out  1               head entry presented to DM
//  mem_ready    in   1               DM takes head when mem_valid&&mem_ready
//  mem_addr     out  ADDR_W          head byte address, low log2(BYTES) bits zero
//  mem_wdata    out  DATA_W          head aligned data
//  mem_byteen   out  BYTES           head byte enables
//  count        out  $clog2(DEPTH)+1 occupied entries
//  empty        out  1               count==0
// BEHAVIOUR
//  Reset (async, rst_n=0): pointers=0, count=0, all entry valids 0; st_misalign=0, mem_valid=0,
//   ld_conflict=0; entry payloads don't-care. Reset mid-drain discards all queued stores.
//  Alignment: lane = st_addr[log2(BYTES)-1:0]. Byte: byteen=1<<lane, data byte at lane*8.
//   Half: byteen=2'b11<<lane, halfword at lane*8. Word: 4'hF<<lane (lane multiple of 4).
//   Unsigned variants align identically. Unknown st_type: byteen=0, entry still enqueued.
//  Misaligned = half with lane[0]=1, or word with lane[1:0]!=0. Accepted (st_ready rules apply),
//   never enqueued or merged; st_misalign=1 the next cycle only.
//  pop = mem_valid&&mem_ready. word match = st_addr[ADDR_W-1:log2(BYTES)] == newest entry's.
//  merge_hit = MERGE && count!=0 && word match && !(count==1 && pop) && !misaligned.
//  st_ready = (count<DEPTH) || merge_hit (merge allowed when full; no path from mem_ready except
//   via merge_hit at count==1).
//  Merge: newest entry byteen |= new byteen; bytes with new byteen set take new data; else kept.
//  Push (accepted, aligned, not merge_hit): write at tail, tail++ mod DEPTH.
//  Simultaneous push+pop: count unchanged; at count==DEPTH with pop, st_ready still 0 unless merge_hit.
//  mem_* driven combinationally from head entry; mem_valid=!empty; stable until pop.
//  Pointers wrap mod DEPTH; count is only full/empty discriminator.
//  ld_conflict compares word addresses of all valid entries (including head being popped same cycle).
//  Latency: accepted store visible on mem_* the next cycle if queue was empty.
// STRUCTURE
//  macro.v gains `DM_TYPE_W (6); existing DM_type codes reused unchanged.
//  Sub-module dm_store_align (comb, parametrised DATA_W): lane+type+data -> byteen, aligned data,
//   misalign. Top holds FIFO regs, pointers, count, merge and hazard compare.
// TESTING
//  sb 0x0000_1003 data 0xAB, MERGE=0 -> next cycle mem_addr 0x1000, byteen 4'b1000, wdata 0xAB00_0000.
//  sh 0x...1002 0x1234 then sb 0x...1000 0x56, mem_ready=0, MERGE=1 -> count=1, byteen 4'b1101,
//   wdata 0x1234_0056.
//  sw 0x2002 -> st_ready=1, nothing enqueued, st_misalign=1 one cycle, count unchanged.
//  DEPTH=4, four sw to distinct words, mem_ready=0 -> count=4, st_ready=0 for new word, =1 for sb to
//   newest word; then mem_ready=1 drains in order, count 4->0.
//  Full queue, push distinct word with pop same cycle -> st_ready=0; next cycle (count=3) push accepted.
//  Queue holds 0x3000; ld_addr 0x3002 -> ld_conflict=1; 0x3004 -> 0; assert rst_n=0 mid-drain ->
//   mem_valid=0, count=0 immediately.

Source files
------------

// File: rtl/dm_store_buffer_pkg.sv
// Shared store-type codes and size decode for the MEM-stage store buffer.
// Store-type codes mirror the DM_type macro values used by the MEM stage.
package dm_store_buffer_pkg;

   localparam int unsigned DM_TYPE_W = 6;

   localparam logic [DM_TYPE_W-1:0] DM_WORD  = 6'd1;
   localparam logic [DM_TYPE_W-1:0] DM_HALF  = 6'd2;
   localparam logic [DM_TYPE_W-1:0] DM_UHALF = 6'd3;
   localparam logic [DM_TYPE_W-1:0] DM_BYTE  = 6'd4;
   localparam logic [DM_TYPE_W-1:0] DM_UBYTE = 6'd5;

   typedef enum logic [1:0] {
      SzNone,
      SzByte,
      SzHalf,
      SzWord
   } dm_size_e;

   // Signed and unsigned variants store identically; only the width matters.
   function automatic dm_size_e dm_size(input logic [DM_TYPE_W-1:0] st_type);
      dm_size_e sz;
      case (st_type)
         DM_WORD:           sz = SzWord;
         DM_HALF, DM_UHALF: sz = SzHalf;
         DM_BYTE, DM_UBYTE: sz = SzByte;
         default:           sz = SzNone;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/dm_store_align.sv
// Combinational store alignment: places sb/sh/sw data in its byte lanes, builds
// byte enables and flags naturally-misaligned half/word stores.
module dm_store_align
   import dm_store_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [$clog2(DATA_W/8)-1:0] lane,
   input  logic [DM_TYPE_W-1:0]        st_type,
   input  logic [DATA_W-1:0]           wdata,
   output logic [DATA_W/8-1:0]         byteen,
   output logic [DATA_W-1:0]           data,
   output logic                        misalign
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);

   logic [OFF_W+2:0] bit_shift;

   assign bit_shift = {lane, 3'b000};

   always_comb begin
      byteen   = '0;
      data     = '0;
      misalign = 1'b0;
      case (dm_size(st_type))
         SzByte: begin
            byteen = BYTES'(1) << lane;
            data   = DATA_W'(wdata[7:0]) << bit_shift;
         end
         SzHalf: begin
            misalign = lane[0];
            byteen   = BYTES'(2'b11) << lane;
            data     = DATA_W'(wdata[15:0]) << bit_shift;
         end
         SzWord: begin
            misalign = (lane[1:0] != 2'b00);
            byteen   = BYTES'(4'hF) << lane;
            data     = DATA_W'(wdata[31:0]) << bit_shift;
         end
         default: begin
            // Unknown type: enqueue a no-op write with no lanes enabled.
            byteen = '0;
            data   = '0;
         end
      endcase
   end

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: aligns stores, queues them in a small FIFO with optional
// same-word merging, drains to data memory via valid/ready and flags load hazards.
module dm_store_buffer
   import dm_store_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned MERGE  = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       st_valid,
   output logic                       st_ready,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_wdata,
   input  logic [DM_TYPE_W-1:0]       st_type,
   output logic                       st_misalign,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_conflict,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W/8-1:0]        mem_byteen,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int unsigned BYTES  = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(BYTES);
   localparam int unsigned WORD_W = ADDR_W - OFF_W;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   // Entries store word addresses only; the byte offset is implied by byteen.
   logic [WORD_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [BYTES-1:0]  be_q   [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, newest;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              misalign_q;

   logic [BYTES-1:0]  al_be;
   logic [DATA_W-1:0] al_data;
   logic              al_mis;
   logic [WORD_W-1:0] st_word, ld_word;
   logic              pop, push, merge_hit, do_merge, accept;
   logic [DATA_W-1:0] merged_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   dm_store_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .lane     (st_addr[OFF_W-1:0]),
      .st_type  (st_type),
      .wdata    (st_wdata),
      .byteen   (al_be),
      .data     (al_data),
      .misalign (al_mis)
   );

   assign st_word = st_addr[ADDR_W-1:OFF_W];
   assign ld_word = ld_addr[ADDR_W-1:OFF_W];
   assign newest  = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - 1'b1;

   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign mem_valid = !empty;
   assign mem_addr  = {addr_q[head_q], {OFF_W{1'b0}}};
   assign mem_wdata = data_q[head_q];
   assign mem_byteen = be_q[head_q];
   assign st_misalign = misalign_q;

   assign pop = mem_valid && mem_ready;

   // Merging into the head while it leaves would lose the store, so it is blocked.
   assign merge_hit = (MERGE != 0) && !empty && (addr_q[newest] == st_word) &&
                      !((count_q == CNT_W'(1)) && pop) && !al_mis;

   assign st_ready = (count_q < CNT_W'(DEPTH)) || merge_hit;
   assign accept   = st_valid && st_ready;
   assign push     = accept && !al_mis && !merge_hit;
   assign do_merge = accept && merge_hit;

   always_comb begin
      merged_data = '0;
      for (int b = 0; b < int'(BYTES); b++) begin
         merged_data[b*8 +: 8] = al_be[b] ? al_data[b*8 +: 8] : data_q[newest][b*8 +: 8];
      end
   end

   always_comb begin
      ld_conflict = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && (addr_q[i] == ld_word)) begin
            ld_conflict = 1'b1;
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (pop) begin
         head_d          = ptr_inc(head_q);
         valid_d[head_q] = 1'b0;
      end
      if (push) begin
         tail_d          = ptr_inc(tail_q);
         valid_d[tail_q] = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         misalign_q <= accept && al_mis;
      end
   end

   // Payload needs no reset: valid_q and count_q gate every use.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= st_word;
         data_q[tail_q] <= al_data;
         be_q[tail_q]   <= al_be;
      end else if (do_merge) begin
         data_q[newest] <= merged_data;
         be_q[newest]   <= be_q[newest] | al_be;
      end
   end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer (merging and non-merging copies).
module tb_dm_store_buffer;
   import dm_store_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [5:0]  st_type;
   logic [31:0] ld_addr;
   logic        mem_ready;

   logic        st_ready, st_misalign, ld_conflict, mem_valid, empty;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_byteen;
   logic [2:0]  count;

   logic        m0_st_ready, m0_st_misalign, m0_ld_conflict, m0_mem_valid, m0_empty;
   logic [31:0] m0_mem_addr, m0_mem_wdata;
   logic [3:0]  m0_mem_byteen;
   logic [2:0]  m0_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dm_store_buffer #(
      .DATA_W (32), .ADDR_W (32), .DEPTH (4), .MERGE (1)
   ) u_dut (
      .clk (clk), .rst_n (rst_n), .st_valid (st_valid), .st_ready (st_ready),
      .st_addr (st_addr), .st_wdata (st_wdata), .st_type (st_type),
      .st_misalign (st_misalign), .ld_addr (ld_addr), .ld_conflict (ld_conflict),
      .mem_valid (mem_valid), .mem_ready (mem_ready), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_byteen (mem_byteen), .count (count), .empty (empty)
   );

   dm_store_buffer #(
      .DATA_W (32), .ADDR_W (32), .DEPTH (4), .MERGE (0)
   ) u_m0 (
      .clk (clk), .rst_n (rst_n), .st_valid (st_valid), .st_ready (m0_st_ready),
      .st_addr (st_addr), .st_wdata (st_wdata), .st_type (st_type),
      .st_misalign (m0_st_misalign), .ld_addr (ld_addr), .ld_conflict (m0_ld_conflict),
      .mem_valid (m0_mem_valid), .mem_ready (mem_ready), .mem_addr (m0_mem_addr),
      .mem_wdata (m0_mem_wdata), .mem_byteen (m0_mem_byteen), .count (m0_count),
      .empty (m0_empty)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
      st_valid = 1'b1;
      st_addr  = a;
      st_wdata = d;
      st_type  = t;
      #1;
   endtask

   task automatic idle();
      st_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_wdata  = '0;
      st_type   = DM_WORD;
      ld_addr   = '0;
      mem_ready = 1'b0;
      #3;
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_misalign", 64'(st_misalign), 64'd0);
      check("rst_ld_conflict", 64'(ld_conflict), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Byte store to lane 3, visible the next cycle.
      store(32'h0000_1003, 32'h0000_00AB, DM_BYTE);
      check("sb_ready", 64'(st_ready), 64'd1);
      step();
      idle();
      check("sb_mem_valid", 64'(mem_valid), 64'd1);
      check("sb_mem_addr", 64'(mem_addr), 64'h1000);
      check("sb_byteen", 64'(mem_byteen), 64'h8);
      check("sb_wdata", 64'(mem_wdata), 64'hAB00_0000);
      check("m0_sb_wdata", 64'(m0_mem_wdata), 64'hAB00_0000);
      check("sb_count", 64'(count), 64'd1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      #1;
      check("sb_drained", 64'(empty), 64'd1);

      // Half then byte to the same word: merged vs. two entries.
      store(32'h0000_1002, 32'h0000_1234, DM_HALF);
      step();
      store(32'h0000_1000, 32'h0000_0056, DM_UBYTE);
      check("merge_ready", 64'(st_ready), 64'd1);
      step();
      idle();
      check("merge_count", 64'(count), 64'd1);
      check("merge_byteen", 64'(mem_byteen), 64'hD);
      check("merge_wdata", 64'(mem_wdata), 64'h1234_0056);
      check("m0_count", 64'(m0_count), 64'd2);
      check("m0_head_byteen", 64'(m0_mem_byteen), 64'hC);
      check("m0_head_wdata", 64'(m0_mem_wdata), 64'h1234_0000);
      mem_ready = 1'b1;
      step();
      step();
      mem_ready = 1'b0;
      #1;
      check("merge_drained", 64'(empty), 64'd1);
      check("m0_drained", 64'(m0_empty), 64'd1);

      // Misaligned word: accepted, dropped, one-cycle flag.
      store(32'h0000_2002, 32'hCAFE_F00D, DM_WORD);
      check("mis_ready", 64'(st_ready), 64'd1);
      step();
      idle();
      check("mis_flag", 64'(st_misalign), 64'd1);
      check("mis_count", 64'(count), 64'd0);
      check("mis_mem_valid", 64'(mem_valid), 64'd0);
      step();
      check("mis_flag_clear", 64'(st_misalign), 64'd0);

      // Fill to DEPTH with distinct words.
      for (int i = 0; i < 4; i++) begin
         store(32'h0000_4000 + 32'(i * 4), {4{8'(8'h11 * (i + 1))}}, DM_WORD);
         step();
      end
      idle();
      check("full_count", 64'(count), 64'd4);
      store(32'h0000_4010, 32'h9999_9999, DM_WORD);
      check("full_new_word_ready", 64'(st_ready), 64'd0);
      store(32'h0000_400D, 32'h0000_0077, DM_BYTE);
      check("full_merge_ready", 64'(st_ready), 64'd1);
      step();
      idle();
      check("full_after_merge", 64'(count), 64'd4);
      ld_addr = 32'h0000_4006;
      #1;
      check("ldc_hit_full", 64'(ld_conflict), 64'd1);
      ld_addr = 32'h0000_4014;
      #1;
      check("ldc_miss_full", 64'(ld_conflict), 64'd0);

      // Full with pop: no push this cycle, push accepted next cycle.
      store(32'h0000_5000, 32'h5555_5555, DM_WORD);
      mem_ready = 1'b1;
      #1;
      check("full_pop_ready", 64'(st_ready), 64'd0);
      check("drain0_addr", 64'(mem_addr), 64'h4000);
      step();
      check("count3_ready", 64'(st_ready), 64'd1);
      check("drain1_addr", 64'(mem_addr), 64'h4004);
      step();
      idle();
      check("pushpop_count", 64'(count), 64'd3);
      check("drain2_addr", 64'(mem_addr), 64'h4008);
      check("drain2_wdata", 64'(mem_wdata), 64'h3333_3333);
      step();
      check("drain3_addr", 64'(mem_addr), 64'h400C);
      check("drain3_wdata", 64'(mem_wdata), 64'h4444_7744);
      check("drain3_byteen", 64'(mem_byteen), 64'hF);
      step();
      check("drain4_addr", 64'(mem_addr), 64'h5000);
      check("drain4_wdata", 64'(mem_wdata), 64'h5555_5555);
      step();
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_count", 64'(count), 64'd0);
      mem_ready = 1'b0;

      // Load hazard, then reset mid-drain.
      store(32'h0000_3000, 32'hDEAD_BEEF, DM_WORD);
      step();
      store(32'h0000_3008, 32'h0BAD_F00D, DM_WORD);
      step();
      idle();
      ld_addr = 32'h0000_3002;
      #1;
      check("ldc_hit", 64'(ld_conflict), 64'd1);
      ld_addr = 32'h0000_3004;
      #1;
      check("ldc_miss", 64'(ld_conflict), 64'd0);
      mem_ready = 1'b1;
      step();
      check("middrain_count", 64'(count), 64'd1);
      ld_addr = 32'h0000_3008;
      rst_n   = 1'b0;
      #1;
      check("rst_mid_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_mid_count", 64'(count), 64'd0);
      check("rst_mid_ldc", 64'(ld_conflict), 64'd0);
      mem_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_empty", 64'(empty), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
